// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and constants: beam/colour widths, tank sprite defaults, timing bus struct.
package vga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int RGB_W    = 12;

  localparam int               TANK_W           = 48;
  localparam int               TANK_H           = 64;
  localparam logic [RGB_W-1:0] TANK_TRANSPARENT = 12'hF0F;

  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [HCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
  } vga_timing_t;

endpackage

// File: rtl/draw_tank_sprite_if.sv
// Pixel stream in/out, sprite position and sprite ROM port of the tank overlay stage.
interface draw_tank_sprite_if;
  import vga_pkg::*;

  logic [HCOUNT_W-1:0] hcount_in;
  logic [HCOUNT_W-1:0] vcount_in;
  logic                hsync_in;
  logic                vsync_in;
  logic                hblnk_in;
  logic                vblnk_in;
  logic [RGB_W-1:0]    rgb_in;
  logic [11:0]         xpos;
  logic [11:0]         ypos;
  logic [11:0]         pixel_addr;
  logic [RGB_W-1:0]    rgb_pixel;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [HCOUNT_W-1:0] vcount_out;
  logic                hsync_out;
  logic                vsync_out;
  logic                hblnk_out;
  logic                vblnk_out;
  logic [RGB_W-1:0]    rgb_out;

  // Sprite stage view
  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  xpos, ypos, rgb_pixel,
    output pixel_addr,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );

  // Upstream pixel source / ROM / downstream sink view
  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output xpos, ypos, rgb_pixel,
    input  pixel_addr,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );

endinterface

// File: rtl/vga_delay.sv
// Fixed-depth shift register for pixel-aligned side signals; DEPTH cycles latency, no backpressure.
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/draw_tank_sprite.sv
// Overlays the tank sprite on the VGA stream using a registered sprite ROM.
// 3-cycle latency on every output, 1 pixel/clk, free-running stream with no backpressure.
module draw_tank_sprite
  import vga_pkg::*;
#(
  parameter int               SPRITE_W    = TANK_W,
  parameter int               SPRITE_H    = TANK_H,
  parameter logic [RGB_W-1:0] TRANSPARENT = TANK_TRANSPARENT
) (
  input logic          clk,
  input logic          rst_n,
  draw_tank_sprite_if.slave vga
);

  localparam int DLY_W = $bits(vga_timing_t) + RGB_W;

  logic        vblnk_prev;
  logic [11:0] x_lat;
  logic [11:0] y_lat;

  logic [11:0] hc12;
  logic [11:0] vc12;
  logic [11:0] dx;
  logic [11:0] dy;
  logic        in_win;

  logic [11:0] pixel_addr_q;
  logic        in_win_d1;
  logic        in_win_d2;

  vga_timing_t      tim_in;
  vga_timing_t      tim_d2;
  vga_timing_t      tim_q;
  logic [RGB_W-1:0] rgb_d2;
  logic [RGB_W-1:0] rgb_q;
  logic [DLY_W-1:0] dly_in;
  logic [DLY_W-1:0] dly_out;

  // Position is sampled only at the start of vertical blanking so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      vblnk_prev <= vga.vblnk_in;
      if (vga.vblnk_in && !vblnk_prev) begin
        x_lat <= vga.xpos;
        y_lat <= vga.ypos;
      end
    end
  end

  always_comb begin
    hc12   = {1'b0, vga.hcount_in};
    vc12   = {1'b0, vga.vcount_in};
    dx     = hc12 - x_lat;
    dy     = vc12 - y_lat;
    in_win = (hc12 >= x_lat) && (dx < 12'(SPRITE_W)) &&
             (vc12 >= y_lat) && (dy < 12'(SPRITE_H)) &&
             !vga.hblnk_in && !vga.vblnk_in;
  end

  always_comb begin
    tim_in        = '0;
    tim_in.hcount = vga.hcount_in;
    tim_in.vcount = vga.vcount_in;
    tim_in.hsync  = vga.hsync_in;
    tim_in.vsync  = vga.vsync_in;
    tim_in.hblnk  = vga.hblnk_in;
    tim_in.vblnk  = vga.vblnk_in;
  end

  assign dly_in          = {tim_in, vga.rgb_in};
  assign {tim_d2, rgb_d2} = dly_out;

  vga_delay #(
    .WIDTH (DLY_W),
    .DEPTH (2)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dly_in),
    .dout  (dly_out)
  );

  // Address issued at stage 1; the ROM answers during stage 2, so in_win rides two flops to meet it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_addr_q <= '0;
      in_win_d1    <= 1'b0;
      in_win_d2    <= 1'b0;
      tim_q        <= '0;
      rgb_q        <= '0;
    end else begin
      pixel_addr_q <= in_win ? {dy[5:0], dx[5:0]} : 12'h000;
      in_win_d1    <= in_win;
      in_win_d2    <= in_win_d1;
      tim_q        <= tim_d2;
      rgb_q        <= (in_win_d2 && (vga.rgb_pixel != TRANSPARENT)) ? vga.rgb_pixel : rgb_d2;
    end
  end

  assign vga.pixel_addr = pixel_addr_q;
  assign vga.hcount_out = tim_q.hcount;
  assign vga.vcount_out = tim_q.vcount;
  assign vga.hsync_out  = tim_q.hsync;
  assign vga.vsync_out  = tim_q.vsync;
  assign vga.hblnk_out  = tim_q.hblnk;
  assign vga.vblnk_out  = tim_q.vblnk;
  assign vga.rgb_out    = rgb_q;

endmodule
